// File: rtl/exc_sequencer_if.sv
// Request/CP0/redirect bundle between the control unit, the exception
// sequencer and CP0. The sequencer uses the slave view.
interface exc_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic             req_ready;
  logic             is_syscall;
  logic             is_break;
  logic             is_teq;
  logic             teq_eq;
  logic             is_eret;
  logic [31:0]      pc_in;
  logic [31:0]      status;
  logic [31:0]      exc_addr;
  logic             exception;
  logic             eret;
  logic [4:0]       cause;
  logic [31:0]      epc;
  logic             busy;
  logic             done;
  logic             taken;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             redirect_ack;
  logic [CNT_W-1:0] exc_count;

  modport slave (
    input  req_valid, is_syscall, is_break, is_teq, teq_eq, is_eret,
           pc_in, status, exc_addr, redirect_ack,
    output req_ready, exception, eret, cause, epc, busy, done, taken,
           redirect_valid, redirect_pc, exc_count
  );

  modport master (
    output req_valid, is_syscall, is_break, is_teq, teq_eq, is_eret,
           pc_in, status, exc_addr, redirect_ack,
    input  req_ready, exception, eret, cause, epc, busy, done, taken,
           redirect_valid, redirect_pc, exc_count
  );
endinterface

// File: rtl/exc_sequencer.sv
// Exception/return sequencer in front of CP0: gates traps with the status
// mask, pulses exception/eret into CP0, then holds a PC redirect built from
// CP0's exc_addr until the PC logic acknowledges it.
module exc_sequencer #(
  parameter int IE_BIT       = 0,
  parameter int SYS_MASK_BIT = 1,
  parameter int BRK_MASK_BIT = 2,
  parameter int TEQ_MASK_BIT = 3,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst,
  exc_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TRAP   = 3'd1,
    S_SETTLE = 3'd2,
    S_ERET   = 3'd3,
    S_REDIR  = 3'd4
  } state_e;

  localparam logic [4:0] CAUSE_SYS = 5'b01000;
  localparam logic [4:0] CAUSE_BRK = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ = 5'b01101;

  state_e           state_q, state_d;
  logic [4:0]       cause_q;
  logic [31:0]      epc_q;
  logic [31:0]      rpc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             taken_q;

  logic             accept;
  logic             trap_sel;
  logic             trap_mask;
  logic [4:0]       trap_cause;
  logic             eret_go;
  logic             trap_go;
  logic             nop_go;
  logic             ack_go;

  assign accept = bus.req_valid && (state_q == S_IDLE);

  // Pick the highest-priority trap flag below eret and its mask bit.
  always_comb begin
    trap_sel   = 1'b0;
    trap_mask  = 1'b0;
    trap_cause = 5'd0;
    if (bus.is_syscall) begin
      trap_sel   = 1'b1;
      trap_mask  = bus.status[SYS_MASK_BIT];
      trap_cause = CAUSE_SYS;
    end else if (bus.is_break) begin
      trap_sel   = 1'b1;
      trap_mask  = bus.status[BRK_MASK_BIT];
      trap_cause = CAUSE_BRK;
    end else if (bus.is_teq && bus.teq_eq) begin
      trap_sel   = 1'b1;
      trap_mask  = bus.status[TEQ_MASK_BIT];
      trap_cause = CAUSE_TEQ;
    end
  end

  // eret wins over every trap; anything else accepted completes at once.
  assign eret_go = accept && bus.is_eret;
  assign trap_go = accept && !bus.is_eret && trap_sel && bus.status[IE_BIT] && trap_mask;
  assign nop_go  = accept && !eret_go && !trap_go;
  assign ack_go  = (state_q == S_REDIR) && bus.redirect_ack;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (eret_go)      state_d = S_ERET;
        else if (trap_go) state_d = S_TRAP;
      end
      S_TRAP:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_REDIR;
      S_ERET:   state_d = S_REDIR;
      S_REDIR:  if (bus.redirect_ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs; exception and eret come from disjoint states.
  always_comb begin
    bus.req_ready      = (state_q == S_IDLE);
    bus.busy           = (state_q != S_IDLE);
    bus.exception      = (state_q == S_TRAP);
    bus.eret           = (state_q == S_ERET);
    bus.redirect_valid = (state_q == S_REDIR);
  end

  // Trap context, redirect target, completion pulse and taken counter.
  // redirect_pc is captured in ERET itself since CP0 shows EPC only then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cause_q <= 5'd0;
      epc_q   <= 32'd0;
      rpc_q   <= 32'd0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      if (trap_go) begin
        cause_q <= trap_cause;
        epc_q   <= bus.pc_in;
      end
      if (state_q == S_SETTLE || state_q == S_ERET)
        rpc_q <= bus.exc_addr;
      if (state_q == S_TRAP && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + CNT_W'(1);
      done_q  <= nop_go || ack_go;
      taken_q <= ack_go;
    end
  end

  assign bus.cause       = cause_q;
  assign bus.epc         = epc_q;
  assign bus.redirect_pc = rpc_q;
  assign bus.exc_count   = cnt_q;
  assign bus.done        = done_q;
  assign bus.taken       = taken_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: a timestamp-based reference model checked every
// cycle, directed scenarios with literal expectations, and a narrow-counter
// twin that sees identical stimulus to exercise saturation.
module tb_exc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exc_sequencer_if #(.CNT_W(16)) bi();
  exc_sequencer_if #(.CNT_W(3))  bs();

  // CP0 stand-in: shows EPC only while eret is pulsed, else the vector 0x4.
  logic [31:0] eret_epc = 32'h0040_0014;
  assign bi.exc_addr = bi.eret ? eret_epc : 32'h0000_0004;
  assign bs.exc_addr = bs.eret ? eret_epc : 32'h0000_0004;

  assign bs.req_valid    = bi.req_valid;
  assign bs.is_syscall   = bi.is_syscall;
  assign bs.is_break     = bi.is_break;
  assign bs.is_teq       = bi.is_teq;
  assign bs.teq_eq       = bi.teq_eq;
  assign bs.is_eret      = bi.is_eret;
  assign bs.pc_in        = bi.pc_in;
  assign bs.status       = bi.status;
  assign bs.redirect_ack = bi.redirect_ack;

  exc_sequencer #(.CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bi.slave));
  exc_sequencer #(.CNT_W(3))  dut_s (.clk(clk), .rst(rst), .bus(bs.slave));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: remembers when a request was accepted and derives every
  // output from its age. kind 0 = idle, 1 = trap, 2 = eret.
  int          cyc = 0;
  int          m_kind, m_acc, m_lat, m_done_edge, m_cnt;
  bit          m_taken;
  logic [4:0]  m_cause;
  logic [31:0] m_epc, m_rpc;

  task automatic m_reset();
    m_kind = 0; m_acc = -100; m_lat = 0; m_done_edge = -100; m_cnt = 0;
    m_taken = 1'b0; m_cause = 5'd0; m_epc = 32'd0; m_rpc = 32'd0;
  endtask

  task automatic m_edge();
    bit hit, en;
    logic [4:0] c;
    if (m_kind == 0) begin
      if (bi.req_valid) begin
        if (bi.is_eret) begin
          m_kind = 2; m_lat = 1; m_acc = cyc;
        end else begin
          hit = 0; en = 0; c = 5'd0;
          if (bi.is_syscall)               begin hit = 1; en = bi.status[1]; c = 5'd8;  end
          else if (bi.is_break)            begin hit = 1; en = bi.status[2]; c = 5'd9;  end
          else if (bi.is_teq && bi.teq_eq) begin hit = 1; en = bi.status[3]; c = 5'd13; end
          if (hit && en && bi.status[0]) begin
            m_kind = 1; m_lat = 2; m_acc = cyc; m_cause = c; m_epc = bi.pc_in;
          end else begin
            m_done_edge = cyc; m_taken = 1'b0;
          end
        end
      end
    end else begin
      if (m_kind == 1 && cyc == m_acc + 1) m_cnt++;
      if (cyc == m_acc + m_lat) m_rpc = bi.exc_addr;
      else if (cyc > m_acc + m_lat && bi.redirect_ack) begin
        m_kind = 0; m_done_edge = cyc; m_taken = 1'b1;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else begin
        cyc++;
        m_edge();
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("req_ready", bi.req_ready, m_kind == 0);
      chk("busy", bi.busy, m_kind != 0);
      chk("exception", bi.exception, m_kind == 1 && cyc == m_acc);
      chk("eret", bi.eret, m_kind == 2 && cyc == m_acc);
      chk("exc_eret_excl", bi.exception & bi.eret, 0);
      chk("redirect_valid", bi.redirect_valid, m_kind != 0 && cyc >= m_acc + m_lat);
      chk("redirect_pc", bi.redirect_pc, m_rpc);
      chk("cause", bi.cause, m_cause);
      chk("epc", bi.epc, m_epc);
      chk("done", bi.done, rst && cyc == m_done_edge);
      chk("taken", bi.taken, rst && cyc == m_done_edge && m_taken);
      chk("exc_count", bi.exc_count, m_cnt);
      chk("exc_count_sat", bs.exc_count, (m_cnt > 7) ? 7 : m_cnt);
    end
  end

  task automatic clear_req();
    bi.req_valid = 0; bi.is_syscall = 0; bi.is_break = 0; bi.is_teq = 0;
    bi.teq_eq = 0; bi.is_eret = 0;
  endtask

  // Present one request once the sequencer is ready; returns at the negedge
  // right after the accepting edge.
  task automatic issue(input bit er, input bit sy, input bit br, input bit tq,
                       input bit tqe, input logic [31:0] st, input logic [31:0] pc);
    int w;
    w = 0;
    while (!bi.req_ready && w < 20) begin @(negedge clk); w++; end
    chk("ready_before_issue", bi.req_ready, 1);
    bi.is_eret = er; bi.is_syscall = sy; bi.is_break = br; bi.is_teq = tq;
    bi.teq_eq = tqe; bi.status = st; bi.pc_in = pc; bi.req_valid = 1;
    @(negedge clk);
    clear_req();
  endtask

  // Wait for the redirect, keep ack low for 'hold' cycles, then ack once.
  task automatic serve_redirect(input int hold);
    int w;
    w = 0;
    while (!bi.redirect_valid && w < 20) begin @(negedge clk); w++; end
    chk("redirect_seen", bi.redirect_valid, 1);
    repeat (hold) @(negedge clk);
    bi.redirect_ack = 1;
    @(negedge clk);
    bi.redirect_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_req();
    bi.status = 32'd0; bi.pc_in = 32'd0; bi.redirect_ack = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bi.req_ready, 1);
    chk("rst_exc_count", bi.exc_count, 0);
    chk("rst_redirect_pc", bi.redirect_pc, 0);
    rst = 1;
    @(negedge clk);

    // Enabled syscall with a slow ack.
    issue(0, 1, 0, 0, 0, 32'h3, 32'h0040_0010);
    chk("sys_exception", bi.exception, 1);
    chk("sys_cause", bi.cause, 32'h08);
    chk("sys_epc", bi.epc, 32'h0040_0010);
    @(negedge clk);
    chk("sys_exc_one_cycle", bi.exception, 0);
    chk("sys_no_rv_yet", bi.redirect_valid, 0);
    @(negedge clk);
    chk("sys_rv_at_3", bi.redirect_valid, 1);
    chk("sys_rpc", bi.redirect_pc, 32'h4);
    repeat (5) @(negedge clk);
    chk("sys_rv_held", bi.redirect_valid, 1);
    bi.redirect_ack = 1;
    @(negedge clk);
    bi.redirect_ack = 0;
    chk("sys_done", bi.done, 1);
    chk("sys_taken", bi.taken, 1);
    chk("sys_rv_drop", bi.redirect_valid, 0);
    chk("sys_count", bi.exc_count, 1);

    // Break masked by its own bit.
    issue(0, 0, 1, 0, 0, 32'h1, 32'h0040_0020);
    chk("brk_masked_done", bi.done, 1);
    chk("brk_masked_taken", bi.taken, 0);
    chk("brk_masked_noexc", bi.exception, 0);
    chk("brk_masked_count", bi.exc_count, 1);

    // Break blocked by the global enable alone.
    issue(0, 0, 1, 0, 0, 32'h4, 32'h0040_0024);
    chk("brk_ie_off_done", bi.done, 1);
    chk("brk_ie_off_taken", bi.taken, 0);

    // No flag at all.
    issue(0, 0, 0, 0, 0, 32'hF, 32'h0040_0028);
    chk("noop_done", bi.done, 1);
    chk("noop_taken", bi.taken, 0);

    // teq without equality, then with it.
    issue(0, 0, 0, 1, 0, 32'h9, 32'h0040_0030);
    chk("teq_ne_done", bi.done, 1);
    chk("teq_ne_taken", bi.taken, 0);
    issue(0, 0, 0, 1, 1, 32'h9, 32'h0040_0034);
    chk("teq_exception", bi.exception, 1);
    chk("teq_cause", bi.cause, 32'h0D);
    chk("teq_epc", bi.epc, 32'h0040_0034);
    serve_redirect(0);
    chk("teq_taken", bi.taken, 1);
    chk("teq_count", bi.exc_count, 2);

    // eret together with syscall: only the return path runs.
    issue(1, 1, 0, 0, 0, 32'h3, 32'h0040_0040);
    chk("eret_pulse", bi.eret, 1);
    chk("eret_no_exc", bi.exception, 0);
    @(negedge clk);
    chk("eret_one_cycle", bi.eret, 0);
    chk("eret_rv_at_2", bi.redirect_valid, 1);
    chk("eret_rpc", bi.redirect_pc, 32'h0040_0014);
    serve_redirect(2);
    chk("eret_done", bi.done, 1);
    chk("eret_count", bi.exc_count, 2);
    chk("eret_cause_kept", bi.cause, 32'h0D);

    // Fill the 3-bit twin to all-ones, then push past it.
    for (int i = 0; i < 5; i++) begin
      issue(0, 1, 0, 0, 0, 32'h3, 32'h0040_0100 + 32'(i * 4));
      serve_redirect(0);
    end
    chk("sat_reach", bs.exc_count, 7);
    for (int i = 0; i < 2; i++) begin
      issue(0, 0, 1, 0, 0, 32'h5, 32'h0040_0200);
      serve_redirect(0);
    end
    chk("sat_hold", bs.exc_count, 7);
    chk("wide_count", bi.exc_count, 9);

    // Async reset in the middle of a held redirect.
    issue(0, 1, 0, 0, 0, 32'h3, 32'h0040_0300);
    begin
      int w;
      w = 0;
      while (!bi.redirect_valid && w < 20) begin @(negedge clk); w++; end
    end
    repeat ($urandom_range(3, 1)) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("arst_rv", bi.redirect_valid, 0);
    chk("arst_busy", bi.busy, 0);
    chk("arst_ready", bi.req_ready, 1);
    chk("arst_count", bi.exc_count, 0);
    chk("arst_rpc", bi.redirect_pc, 0);
    chk("arst_epc", bi.epc, 0);
    chk("arst_cause", bi.cause, 0);
    chk("arst_done", bi.done, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("post_rst_ready", bi.req_ready, 1);
    chk("post_rst_done", bi.done, 0);
    issue(0, 1, 0, 0, 0, 32'h3, 32'h0040_0400);
    serve_redirect(1);
    chk("post_rst_count", bi.exc_count, 1);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
